// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and forwarding unit for the decode stage. It keeps a
//   DEPTH-entry shift-register scoreboard of in-flight destinations. From it,
//   the unit produces the following for the decode instruction:
//   - per-operand forwarding selects,
//   - a stall,
//   - a multi-cycle kill after an accepted redirect.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   id_valid                 decode holds a real instruction
//   id_rs1/id_rs2            source register addresses
//   id_rs1_used/id_rs2_used  instruction reads that source
//   id_rd, id_we             destination address / writes id_rd
//   id_is_load               instruction is a load
//   id_redirect              jump or taken branch in decode
//   stall                    hold PC and decode, insert bubble
//   kill                     discard decode instruction, insert bubble
//   issue                    decode instruction enters stage 1 this cycle
//   fwd_a_sel/fwd_b_sel      0 = register file, k = stage k result
module hazard_scoreboard #(
    parameter int DEPTH       = 3,
    parameter int FWD_EN      = 1,
    parameter int LOAD_LAT    = 2,
    parameter int KILL_CYCLES = 1,
    parameter int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             id_redirect,
    output logic             stall,
    output logic             kill,
    output logic             issue,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel
);

    localparam int KC_W = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;

    // Scoreboard: index 1 is the youngest stage, index DEPTH is writeback.
    logic [DEPTH:1] v_q, v_d;
    logic [DEPTH:1] we_q, we_d;
    logic [DEPTH:1] ld_q, ld_d;
    logic [4:0]     rd_q [1:DEPTH];
    logic [4:0]     rd_d [1:DEPTH];
    logic [KC_W-1:0] kc_q, kc_d;

    logic             hit_a, hit_b, ld_a, ld_b, haz_a, haz_b;
    logic [SEL_W-1:0] k_a, k_b, sel_a, sel_b;

    // Youngest matching writer wins: scan from stage 1 and lock on the first hit.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        k_a   = '0;
        k_b   = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (!hit_a && v_q[k] && we_q[k] && rd_q[k] == id_rs1) begin
                hit_a = 1'b1;
                k_a   = SEL_W'(k);
                ld_a  = ld_q[k];
            end
            if (!hit_b && v_q[k] && we_q[k] && rd_q[k] == id_rs2) begin
                hit_b = 1'b1;
                k_b   = SEL_W'(k);
                ld_b  = ld_q[k];
            end
        end
    end

    always_comb begin
        haz_a = 1'b0;
        sel_a = '0;
        if (id_rs1_used && id_rs1 != 5'd0 && hit_a) begin
            if (FWD_EN == 0)
                haz_a = 1'b1;
            else if (ld_a && k_a < SEL_W'(LOAD_LAT))
                haz_a = 1'b1;
            else
                sel_a = k_a;
        end
        haz_b = 1'b0;
        sel_b = '0;
        if (id_rs2_used && id_rs2 != 5'd0 && hit_b) begin
            if (FWD_EN == 0)
                haz_b = 1'b1;
            else if (ld_b && k_b < SEL_W'(LOAD_LAT))
                haz_b = 1'b1;
            else
                sel_b = k_b;
        end
    end

    // Kill dominates: it masks stall and zeroes the selects.
    assign kill      = (kc_q != '0);
    assign stall     = id_valid && !kill && (haz_a || haz_b);
    assign issue     = id_valid && !stall && !kill;
    assign fwd_a_sel = kill ? '0 : sel_a;
    assign fwd_b_sel = kill ? '0 : sel_b;

    always_comb begin
        v_d  = '0;
        we_d = '0;
        ld_d = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) rd_d[k] = '0;
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            v_d[k]  = v_q[k-1];
            we_d[k] = we_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
        end
        // A non-issuing cycle shifts in a bubble (all fields zero).
        v_d[1]  = issue;
        we_d[1] = issue && id_we && (id_rd != 5'd0);
        ld_d[1] = issue && id_is_load;
        rd_d[1] = issue ? id_rd : 5'd0;

        // Redirect is only honoured when its instruction actually issues.
        if (issue && id_redirect)
            kc_d = KC_W'(KILL_CYCLES);
        else if (kc_q != '0)
            kc_d = kc_q - KC_W'(1);
        else
            kc_d = kc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            we_q <= '0;
            ld_q <= '0;
            kc_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
        end else begin
            v_q  <= v_d;
            we_q <= we_d;
            ld_q <= ld_d;
            kc_q <= kc_d;
            for (int unsigned k = 1; k <= DEPTH; k++) rd_q[k] <= rd_d[k];
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, id_redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;

    // u0: defaults, u1: FWD_EN=0, u2: KILL_CYCLES=2
    logic       stall0, kill0, issue0, stall1, kill1, issue1, stall2, kill2, issue2;
    logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_redirect(id_redirect), .stall(stall0), .kill(kill0),
        .issue(issue0), .fwd_a_sel(fa0), .fwd_b_sel(fb0)
    );

    hazard_scoreboard #(.FWD_EN(0)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_redirect(id_redirect), .stall(stall1), .kill(kill1),
        .issue(issue1), .fwd_a_sel(fa1), .fwd_b_sel(fb1)
    );

    hazard_scoreboard #(.KILL_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_redirect(id_redirect), .stall(stall2), .kill(kill2),
        .issue(issue2), .fwd_a_sel(fa2), .fwd_b_sel(fb2)
    );

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic rdr);
        id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd;    id_we = we;   id_is_load = ld;  id_redirect = rdr;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 5, 1, 6, 1, 0, 0, 0, 0);
        #3;
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %0b want 0", stall0); end
        vectors++; if (kill0 !== 1'b0) begin miscompares++; $display("FAIL reset_kill: got %0b want 0", kill0); end
        vectors++; if (fa0 !== 2'd0) begin miscompares++; $display("FAIL reset_fwd_a: got %0d want 0", fa0); end
        vectors++; if (fb0 !== 2'd0) begin miscompares++; $display("FAIL reset_fwd_b: got %0d want 0", fb0); end
        vectors++; if (issue0 !== 1'b1) begin miscompares++; $display("FAIL reset_issue: got %0b want 1", issue0); end
        vectors++; if (kill2 !== 1'b0) begin miscompares++; $display("FAIL reset_kill_k2: got %0b want 0", kill2); end
        vectors++; if (stall1 !== 1'b0) begin miscompares++; $display("FAIL reset_stall_nofwd: got %0b want 0", stall1); end
    endtask

    task automatic test_forward();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);               // addi x5
        #3;
        vectors++; if (issue0 !== 1'b1) begin miscompares++; $display("FAIL fwd_writer_issue: got %0b want 1", issue0); end
        tick();
        drive(1, 5, 1, 0, 0, 8, 1, 0, 0);               // add rs1=x5
        #3;
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL fwd1_stall: got %0b want 0", stall0); end
        vectors++; if (fa0 !== 2'd1) begin miscompares++; $display("FAIL fwd1_sel_a: got %0d want 1", fa0); end
        vectors++; if (issue0 !== 1'b1) begin miscompares++; $display("FAIL fwd1_issue: got %0b want 1", issue0); end

        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);               // addi x5
        tick();
        drive(1, 1, 1, 0, 0, 9, 1, 0, 0);               // independent, writes x9
        tick();
        drive(1, 5, 1, 9, 1, 8, 1, 0, 0);               // reads x5 and x9
        #3;
        vectors++; if (fa0 !== 2'd2) begin miscompares++; $display("FAIL fwd2_sel_a: got %0d want 2", fa0); end
        vectors++; if (fb0 !== 2'd1) begin miscompares++; $display("FAIL fwd2_sel_b: got %0d want 1", fb0); end
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL fwd2_stall: got %0b want 0", stall0); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);               // lw x6
        tick();
        drive(1, 0, 0, 6, 1, 10, 1, 0, 0);              // add rs2=x6
        #3;
        vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %0b want 1", stall0); end
        vectors++; if (issue0 !== 1'b0) begin miscompares++; $display("FAIL lu_issue: got %0b want 0", issue0); end
        vectors++; if (fb0 !== 2'd0) begin miscompares++; $display("FAIL lu_sel_b: got %0d want 0", fb0); end
        tick();
        #3;
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL lu2_stall: got %0b want 0", stall0); end
        vectors++; if (fb0 !== 2'd2) begin miscompares++; $display("FAIL lu2_sel_b: got %0d want 2", fb0); end
        vectors++; if (issue0 !== 1'b1) begin miscompares++; $display("FAIL lu2_issue: got %0b want 1", issue0); end
        tick();
    endtask

    task automatic test_no_forward();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);               // add x7
        tick();
        drive(1, 7, 1, 0, 0, 11, 1, 0, 0);              // sub rs1=x7, held
        for (int c = 1; c <= 3; c++) begin
            #3;
            vectors++; if (stall1 !== 1'b1) begin miscompares++; $display("FAIL nofwd_stall c%0d: got %0b want 1", c, stall1); end
            vectors++; if (issue1 !== 1'b0) begin miscompares++; $display("FAIL nofwd_issue c%0d: got %0b want 0", c, issue1); end
            tick();
        end
        #3;
        vectors++; if (stall1 !== 1'b0) begin miscompares++; $display("FAIL nofwd_release_stall: got %0b want 0", stall1); end
        vectors++; if (issue1 !== 1'b1) begin miscompares++; $display("FAIL nofwd_release_issue: got %0b want 1", issue1); end
        vectors++; if (fa1 !== 2'd0) begin miscompares++; $display("FAIL nofwd_sel_a: got %0d want 0", fa1); end
        tick();
    endtask

    task automatic test_kill();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 1);               // jal x1, redirect
        #3;
        vectors++; if (issue2 !== 1'b1) begin miscompares++; $display("FAIL kill_jal_issue: got %0b want 1", issue2); end
        vectors++; if (kill2 !== 1'b0) begin miscompares++; $display("FAIL kill_c0: got %0b want 0", kill2); end
        tick();
        drive(1, 1, 1, 0, 0, 12, 1, 0, 1);              // redirect held, reads x1
        for (int c = 1; c <= 2; c++) begin
            #3;
            vectors++; if (kill2 !== 1'b1) begin miscompares++; $display("FAIL kill_c%0d: got %0b want 1", c, kill2); end
            vectors++; if (issue2 !== 1'b0) begin miscompares++; $display("FAIL kill_issue_c%0d: got %0b want 0", c, issue2); end
            vectors++; if (stall2 !== 1'b0) begin miscompares++; $display("FAIL kill_stall_c%0d: got %0b want 0", c, stall2); end
            vectors++; if (fa2 !== 2'd0) begin miscompares++; $display("FAIL kill_sel_c%0d: got %0d want 0", c, fa2); end
            tick();
        end
        drive(1, 1, 1, 0, 0, 12, 1, 0, 0);
        #3;
        vectors++; if (kill2 !== 1'b0) begin miscompares++; $display("FAIL kill_c3: got %0b want 0", kill2); end
        vectors++; if (issue2 !== 1'b1) begin miscompares++; $display("FAIL kill_issue_c3: got %0b want 1", issue2); end
        vectors++; if (fa2 !== 2'd3) begin miscompares++; $display("FAIL kill_sel_stage3: got %0d want 3", fa2); end
        tick();
        #3;
        vectors++; if (kill2 !== 1'b0) begin miscompares++; $display("FAIL kill_c4: got %0b want 0", kill2); end
        vectors++; if (fa2 !== 2'd0) begin miscompares++; $display("FAIL kill_sel_retired: got %0d want 0", fa2); end
        tick();
    endtask

    task automatic test_x0_and_youngest();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);               // lw x0
        tick();
        drive(1, 0, 1, 0, 1, 5, 1, 0, 0);               // reads x0 twice, writes x5
        #3;
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL x0_stall: got %0b want 0", stall0); end
        vectors++; if (fa0 !== 2'd0) begin miscompares++; $display("FAIL x0_sel_a: got %0d want 0", fa0); end
        vectors++; if (fb0 !== 2'd0) begin miscompares++; $display("FAIL x0_sel_b: got %0d want 0", fb0); end
        vectors++; if (stall1 !== 1'b0) begin miscompares++; $display("FAIL x0_stall_nofwd: got %0b want 0", stall1); end
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);               // second writer of x5
        tick();
        drive(1, 5, 1, 5, 1, 13, 1, 0, 0);
        #3;
        vectors++; if (fa0 !== 2'd1) begin miscompares++; $display("FAIL youngest_sel_a: got %0d want 1", fa0); end
        vectors++; if (fb0 !== 2'd1) begin miscompares++; $display("FAIL youngest_sel_b: got %0d want 1", fb0); end
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL youngest_stall: got %0b want 0", stall0); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);               // lw x6
        tick();
        drive(1, 0, 0, 6, 1, 10, 1, 0, 0);
        #3;
        vectors++; if (stall0 !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_stall: got %0b want 1", stall0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        vectors++; if (stall0 !== 1'b0) begin miscompares++; $display("FAIL rmid_stall: got %0b want 0", stall0); end
        vectors++; if (kill0 !== 1'b0) begin miscompares++; $display("FAIL rmid_kill: got %0b want 0", kill0); end
        vectors++; if (fb0 !== 2'd0) begin miscompares++; $display("FAIL rmid_sel_b: got %0d want 0", fb0); end
        vectors++; if (issue0 !== 1'b1) begin miscompares++; $display("FAIL rmid_issue: got %0b want 1", issue0); end
        tick();

        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 1);               // jal, redirect
        tick();
        #3;
        vectors++; if (kill2 !== 1'b1) begin miscompares++; $display("FAIL rkill_pre: got %0b want 1", kill2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        vectors++; if (kill2 !== 1'b0) begin miscompares++; $display("FAIL rkill_post: got %0b want 0", kill2); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        test_reset();
        test_forward();
        test_load_use();
        test_no_forward();
        test_kill();
        test_x0_and_youngest();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
